// File: rtl/fact_result_reader_pkg.sv
// fact_result_reader_pkg: shared widths, read addresses and STATUS word layout
package fact_result_reader_pkg;
  localparam int DW = 32;
  localparam int EW = DW + 1;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_RESULT = 2'd1;
  localparam logic [1:0] ADDR_PEEK = 2'd2;
  localparam logic [1:0] ADDR_CLEAR = 2'd3;
  localparam int ST_NE = 0;
  localparam int ST_FULL = 1;
  localparam int ST_ERR = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
  function automatic logic [5:0] status_bits(input logic [1:0] cnt, input logic ovf, input logic err,
                                             input logic full, input logic ne);
    logic [5:0] s;
    s = '0;
    s[ST_CNT +: 2] = cnt;
    s[ST_OVF] = ovf;
    s[ST_ERR] = err;
    s[ST_FULL] = full;
    s[ST_NE] = ne;
    return s;
  endfunction
endpackage

// File: rtl/fact_result_reader_if.sv
// fact_result_reader_if: core result inputs plus memory-mapped read port
interface fact_result_reader_if;
  import fact_result_reader_pkg::*;
  logic core_done;
  logic core_err;
  logic [DW-1:0] core_result;
  logic rd_en;
  logic [1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic irq;
  modport master (output core_done, core_err, core_result, rd_en, rd_addr, input rd_data, rd_valid, irq);
  modport slave (input core_done, core_err, core_result, rd_en, rd_addr, output rd_data, rd_valid, irq);
endinterface

// File: rtl/fact_result_fifo.sv
// fact_result_fifo: 2-entry synchronous FIFO with push/pop/flush and occupancy count
module fact_result_fifo
  import fact_result_reader_pkg::*;
#(
  parameter int W = EW
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic head, tail, do_pop, do_push;
  assign empty = count == 2'd0;
  assign full = count == 2'd2;
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees a slot, so a push into a full buffer still lands
  assign do_push = push & (~full | do_pop);
  assign dout = mem[head];
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      head <= 1'b0;
      tail <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      head <= 1'b0;
      tail <= push;
      count <= {1'b0, push};
      if (push) mem[0] <= din;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail <= ~tail;
      end
      if (do_pop) head <= ~head;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/fact_result_reader.sv
// fact_result_reader: buffers factorial core results and serves them on a registered read port
module fact_result_reader
  import fact_result_reader_pkg::*;
(
  input logic clock,
  input logic rst_n,
  fact_result_reader_if.slave bus
);
  logic done_q, done_rise, pop, clear, overflow, full, empty, head_err;
  logic [1:0] count;
  logic [EW-1:0] head;
  logic [DW-1:0] status, rd_next;
  assign done_rise = bus.core_done & ~done_q;
  assign pop = bus.rd_en & (bus.rd_addr == ADDR_RESULT) & ~empty;
  assign clear = bus.rd_en & (bus.rd_addr == ADDR_CLEAR);
  assign head_err = ~empty & head[DW];
  assign status = {{(DW-6){1'b0}}, status_bits(count, overflow, head_err, full, ~empty)};
  assign bus.irq = ~empty;
  always_comb rd_next = (bus.rd_addr == ADDR_STATUS || bus.rd_addr == ADDR_CLEAR) ? status :
                        empty ? '0 : head[DW-1:0];
  fact_result_fifo #(.W(EW)) u_fifo (
    .clock(clock),
    .rst_n(rst_n),
    .push(done_rise),
    .pop(pop),
    .flush(clear),
    .din({bus.core_err, bus.core_result}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      overflow <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      done_q <= bus.core_done;
      overflow <= clear ? 1'b0 : overflow | (done_rise & full & ~pop);
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_next;
    end
  end
endmodule
